// File: rtl/sb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sb_pkg                                                       |
// | Description : Shared defaults and entry type for the store buffer slice.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sb_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF    = 32;
  localparam int DW_DEF    = 32;
  localparam int PTR_W     = $clog2(DEPTH_DEF);

  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:2] addr;
    logic [DW_DEF-1:0] data;
  } sb_entry_t;
endpackage
`default_nettype wire

// File: rtl/store_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : store_buffer_if                                              |
// | Description : CPU load/store bus between the pipeline and the store buffer.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface store_buffer_if
  import sb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_stall;

  modport master (
    output st_valid, st_addr, st_data, ld_req, ld_addr,
    input  st_ready, ld_data, ld_stall
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_req, ld_addr,
    output st_ready, ld_data, ld_stall
  );
endinterface
`default_nettype wire

// File: rtl/sb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sb_fifo                                                      |
// | Description : Store-buffer entry storage, pointers, occupancy and flags.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sb_fifo
  import sb_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int AW    = AW_DEF,
  parameter  int DW    = DW_DEF,
  localparam int IW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire logic [AW-3:0]    i_push_addr,
  input  wire logic [DW-1:0]    i_push_data,
  input  wire logic             i_pop,
  output logic      [DEPTH-1:0] o_valid,
  output logic      [AW-3:0]    o_addr [DEPTH],
  output logic      [DW-1:0]    o_data [DEPTH],
  output logic      [IW-1:0]    o_rd_ptr,
  output logic      [IW-1:0]    o_wr_ptr,
  output logic      [CW-1:0]    o_count,
  output logic                  o_full,
  output logic                  o_empty
);
  logic [DEPTH-1:0] r_valid;
  logic [AW-3:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [IW-1:0]    r_rd_ptr;
  logic [IW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + IW'(1);
      end
      if (i_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + IW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: the valid bits alone qualify every entry.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_valid  = r_valid;
  assign o_addr   = r_addr;
  assign o_data   = r_data;
  assign o_rd_ptr = r_rd_ptr;
  assign o_wr_ptr = r_wr_ptr;
  assign o_count  = r_count;
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : store_buffer                                                 |
// | Description : Posted-write buffer and memory-port arbiter; define          |
// |               SB_FWD_EN to forward load hits instead of stalling them.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module store_buffer
  import sb_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int AW    = AW_DEF,
  parameter  int DW    = DW_DEF,
  localparam int IW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  store_buffer_if.slave      cpu,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  wire logic [DW-1:0] mem_rdata,
  output logic [CW-1:0]      buf_count,
  output logic               buf_empty,
  output logic               buf_full
);
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_valid;
  logic [AW-3:0]    w_addr [DEPTH];
  logic [DW-1:0]    w_data [DEPTH];
  logic [IW-1:0]    w_rd_ptr;
  logic [IW-1:0]    w_wr_ptr;
  logic             w_hit;
`ifdef SB_FWD_EN
  logic [DW-1:0]    w_hit_data;
`endif
  logic             w_unused_st;

  assign w_unused_st  = ^cpu.st_addr[1:0];
  assign cpu.st_ready = !buf_full;
  assign w_push       = cpu.st_valid && !buf_full;

  sb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_addr (cpu.st_addr[AW-1:2]),
    .i_push_data (cpu.st_data),
    .i_pop       (w_pop),
    .o_valid     (w_valid),
    .o_addr      (w_addr),
    .o_data      (w_data),
    .o_rd_ptr    (w_rd_ptr),
    .o_wr_ptr    (w_wr_ptr),
    .o_count     (buf_count),
    .o_full      (buf_full),
    .o_empty     (buf_empty)
  );

  // Walk from the youngest entry back to the oldest so the first match wins.
  always_comb begin : p_hit
    logic [IW-1:0] w_idx;
    w_hit = 1'b0;
`ifdef SB_FWD_EN
    w_hit_data = '0;
`endif
    w_idx = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_idx = w_wr_ptr - IW'(k);
      if (!w_hit && w_valid[w_idx] && (w_addr[w_idx] == cpu.ld_addr[AW-1:2])) begin
        w_hit = 1'b1;
`ifdef SB_FWD_EN
        w_hit_data = w_data[w_idx];
`endif
      end
    end
  end

  always_comb begin : p_arb
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    cpu.ld_stall = 1'b0;
    cpu.ld_data  = '0;
    w_pop        = 1'b0;
    if (!rst) begin
      if (buf_full) begin
        w_pop        = 1'b1;
        cpu.ld_stall = cpu.ld_req;
      end else if (cpu.ld_req && w_hit) begin
        w_pop = 1'b1;
`ifdef SB_FWD_EN
        cpu.ld_data = w_hit_data;
`else
        cpu.ld_stall = 1'b1;
`endif
      end else if (cpu.ld_req) begin
        mem_rd      = 1'b1;
        mem_addr    = cpu.ld_addr;
        cpu.ld_data = mem_rdata;
      end else if (!buf_empty) begin
        w_pop = 1'b1;
      end
      if (w_pop) begin
        mem_wr    = 1'b1;
        mem_addr  = {w_addr[w_rd_ptr], 2'b00};
        mem_wdata = w_data[w_rd_ptr];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_store_buffer                                              |
// | Description : Directed vector bench for store_buffer with a memory model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_store_buffer;
  typedef struct {
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        e_ready;
    logic        e_stall;
    logic [31:0] e_ld_data;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [2:0]  e_count;
  } vec_t;

`ifdef SB_FWD_EN
  localparam logic C_HIT_STALL = 1'b0;
`else
  localparam logic C_HIT_STALL = 1'b1;
`endif
  localparam int NV = 29;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  buf_count;
  logic        buf_empty, buf_full;
  logic [31:0] mem [256];
  vec_t        vecs [NV];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  store_buffer_if #(.AW(32), .DW(32)) bus ();

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (bus),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .buf_count (buf_count),
    .buf_empty (buf_empty),
    .buf_full  (buf_full)
  );

  // data_memory stand-in: asynchronous read, write on the clock edge.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lr, input logic [31:0] la);
    bus.st_valid = sv;
    bus.st_addr  = sa;
    bus.st_data  = sd;
    bus.ld_req   = lr;
    bus.ld_addr  = la;
  endtask

  function automatic vec_t mkv(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                               input logic lr, input logic [31:0] la,
                               input logic rdy, input logic stl, input logic [31:0] ldd,
                               input logic rd, input logic wr, input logic [31:0] ma,
                               input logic [31:0] md, input logic [2:0] cnt);
    vec_t v;
    v.st_valid = sv;  v.st_addr = sa;  v.st_data = sd;
    v.ld_req   = lr;  v.ld_addr = la;
    v.e_ready  = rdy; v.e_stall = stl; v.e_ld_data = ldd;
    v.e_rd     = rd;  v.e_wr    = wr;  v.e_addr    = ma;
    v.e_wdata  = md;  v.e_count = cnt;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]    = 32'hF;
    mem[8'h40] = 32'h1234;
    mem[8'h80] = 32'h5A5A;
    mem[8'hC0] = 32'h3C3C;

    // fill with a missing load so nothing drains, then idle drains in order
    vecs[0]  = mkv(1, 32'h00, 32'h11, 1, 32'h200, 1, 0, 32'h5A5A, 1, 0, 32'h200, 0, 0);
    vecs[1]  = mkv(1, 32'h04, 32'h22, 1, 32'h200, 1, 0, 32'h5A5A, 1, 0, 32'h200, 0, 1);
    vecs[2]  = mkv(1, 32'h08, 32'h33, 1, 32'h200, 1, 0, 32'h5A5A, 1, 0, 32'h200, 0, 2);
    vecs[3]  = mkv(1, 32'h0C, 32'h44, 1, 32'h200, 1, 0, 32'h5A5A, 1, 0, 32'h200, 0, 3);
    vecs[4]  = mkv(1, 32'h30, 32'h99, 0, 32'h0,   0, 0, 32'h0,    0, 1, 32'h00,  32'h11, 4);
    vecs[5]  = mkv(0, 32'h0,  32'h0,  0, 32'h0,   1, 0, 32'h0,    0, 1, 32'h04,  32'h22, 3);
    vecs[6]  = mkv(0, 32'h0,  32'h0,  0, 32'h0,   1, 0, 32'h0,    0, 1, 32'h08,  32'h33, 2);
    vecs[7]  = mkv(0, 32'h0,  32'h0,  0, 32'h0,   1, 0, 32'h0,    0, 1, 32'h0C,  32'h44, 1);
    vecs[8]  = mkv(0, 32'h0,  32'h0,  0, 32'h0,   1, 0, 32'h0,    0, 0, 32'h0,   0, 0);
    // store then load of the same word
    vecs[9]  = mkv(1, 32'h10, 32'hDEAD, 0, 32'h0, 1, 0, 32'h0,    0, 0, 32'h0,   0, 0);
    vecs[10] = mkv(0, 32'h0,  32'h0,  1, 32'h10,  1, C_HIT_STALL, 32'hDEAD, 0, 1, 32'h10, 32'hDEAD, 1);
    vecs[11] = mkv(0, 32'h0,  32'h0,  1, 32'h10,  1, 0, 32'hDEAD, 1, 0, 32'h10,  0, 0);
    // two stores to one word, load with nonzero low bits
    vecs[12] = mkv(1, 32'h20, 32'h1,  1, 32'h200, 1, 0, 32'h5A5A, 1, 0, 32'h200, 0, 0);
    vecs[13] = mkv(1, 32'h20, 32'h2,  1, 32'h200, 1, 0, 32'h5A5A, 1, 0, 32'h200, 0, 1);
    vecs[14] = mkv(0, 32'h0,  32'h0,  1, 32'h22,  1, C_HIT_STALL, 32'h2, 0, 1, 32'h20, 32'h1, 2);
    vecs[15] = mkv(0, 32'h0,  32'h0,  1, 32'h22,  1, C_HIT_STALL, 32'h2, 0, 1, 32'h20, 32'h2, 1);
    vecs[16] = mkv(0, 32'h0,  32'h0,  1, 32'h22,  1, 0, 32'h2,    1, 0, 32'h22,  0, 0);
    // full buffer with continuous stores and a missing load
    for (int i = 0; i < 4; i++)
      vecs[17+i] = mkv(1, 32'h40 + 32'(4*i), 32'hA0 + 32'(i), 1, 32'h300,
                       1, 0, 32'h3C3C, 1, 0, 32'h300, 0, 3'(i));
    vecs[21] = mkv(1, 32'h50, 32'hA4, 1, 32'h300, 0, 1, 32'h0,    0, 1, 32'h40,  32'hA0, 4);
    vecs[22] = mkv(1, 32'h50, 32'hA4, 1, 32'h300, 1, 0, 32'h3C3C, 1, 0, 32'h300, 0, 3);
    vecs[23] = mkv(1, 32'h54, 32'hA5, 0, 32'h0,   0, 0, 32'h0,    0, 1, 32'h44,  32'hA1, 4);
    vecs[24] = mkv(1, 32'h54, 32'hA5, 0, 32'h0,   1, 0, 32'h0,    0, 1, 32'h48,  32'hA2, 3);
    vecs[25] = mkv(0, 32'h0,  32'h0,  0, 32'h0,   1, 0, 32'h0,    0, 1, 32'h4C,  32'hA3, 3);
    vecs[26] = mkv(0, 32'h0,  32'h0,  0, 32'h0,   1, 0, 32'h0,    0, 1, 32'h50,  32'hA4, 2);
    vecs[27] = mkv(0, 32'h0,  32'h0,  0, 32'h0,   1, 0, 32'h0,    0, 1, 32'h54,  32'hA5, 1);
    vecs[28] = mkv(0, 32'h0,  32'h0,  0, 32'h0,   1, 0, 32'h0,    0, 0, 32'h0,   0, 0);

    // reset state, with requests present to prove they are masked
    rst = 1'b1;
    drive(1, 32'h0, 32'h77, 1, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", 0, 32'(buf_empty), 1);
    chk("rst_full", 0, 32'(buf_full), 0);
    chk("rst_count", 0, 32'(buf_count), 0);
    chk("rst_ready", 0, 32'(bus.st_ready), 1);
    chk("rst_mem_rd", 0, 32'(mem_rd), 0);
    chk("rst_mem_wr", 0, 32'(mem_wr), 0);
    chk("rst_stall", 0, 32'(bus.ld_stall), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // queued stores discarded by a mid-operation reset
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(4*i), 32'hAAA0 + 32'(i), 1, 32'h100);
      @(negedge clk);
      chk("r5_mem_wr", i, 32'(mem_wr), 0);
      chk("r5_mem_rd", i, 32'(mem_rd), 1);
      chk("r5_count", i, 32'(buf_count), 32'(i));
      chk("r5_ld_data", i, bus.ld_data, 32'h1234);
      @(posedge clk); #1;
    end
    drive(0, 32'h0, 32'h0, 1, 32'h100);
    @(negedge clk);
    chk("r5_count_pre", 3, 32'(buf_count), 3);
    rst = 1'b1;
    #1;
    chk("r5_empty", 3, 32'(buf_empty), 1);
    chk("r5_count_rst", 3, 32'(buf_count), 0);
    chk("r5_mem_wr_rst", 3, 32'(mem_wr), 0);
    chk("r5_mem_rd_rst", 3, 32'(mem_rd), 0);
    chk("r5_stall_rst", 3, 32'(bus.ld_stall), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("r5_idle_wr", i, 32'(mem_wr), 0);
      chk("r5_idle_empty", i, 32'(buf_empty), 1);
      @(posedge clk); #1;
    end
    chk("r5_mem0", 0, mem[0], 32'hF);
    chk("r5_mem1", 1, mem[1], 32'h0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].st_valid, vecs[i].st_addr, vecs[i].st_data, vecs[i].ld_req, vecs[i].ld_addr);
      @(negedge clk);
      chk("v_ready", i, 32'(bus.st_ready), 32'(vecs[i].e_ready));
      chk("v_stall", i, 32'(bus.ld_stall), 32'(vecs[i].e_stall));
      chk("v_mem_rd", i, 32'(mem_rd), 32'(vecs[i].e_rd));
      chk("v_mem_wr", i, 32'(mem_wr), 32'(vecs[i].e_wr));
      chk("v_mem_addr", i, mem_addr, vecs[i].e_addr);
      chk("v_count", i, 32'(buf_count), 32'(vecs[i].e_count));
      chk("v_full", i, 32'(buf_full), 32'(vecs[i].e_count == 3'd4));
      chk("v_empty", i, 32'(buf_empty), 32'(vecs[i].e_count == 3'd0));
      if (vecs[i].ld_req && !vecs[i].e_stall) chk("v_ld_data", i, bus.ld_data, vecs[i].e_ld_data);
      if (vecs[i].e_wr) chk("v_wdata", i, mem_wdata, vecs[i].e_wdata);
      @(posedge clk); #1;
    end

    // steady push+pop across several pointer wraps
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h80 + 32'(4*i), 32'hB00 + 32'(i), 1, 32'h200);
      @(negedge clk);
      chk("w_pre_count", i, 32'(buf_count), 32'(i));
      chk("w_pre_wr", i, 32'(mem_wr), 0);
      @(posedge clk); #1;
    end
    for (int j = 0; j < 11; j++) begin
      if (j < 9) drive(1, 32'h80 + 32'(4*(j+2)), 32'hB00 + 32'(j+2), 0, 32'h0);
      else       drive(0, 32'h0, 32'h0, 0, 32'h0);
      @(negedge clk);
      chk("w_count", j, 32'(buf_count), (j < 9) ? 32'd2 : 32'(11 - j));
      chk("w_wr", j, 32'(mem_wr), 1);
      chk("w_addr", j, mem_addr, 32'h80 + 32'(4*j));
      chk("w_wdata", j, mem_wdata, 32'hB00 + 32'(j));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("w_final_empty", 0, 32'(buf_empty), 1);

    for (int i = 0; i < 4; i++) chk("mem_t1", i, mem[i], 32'h11 * 32'(i+1));
    chk("mem_rejected", 12, mem[12], 32'h0);
    chk("mem_t2", 4, mem[4], 32'hDEAD);
    chk("mem_t3", 8, mem[8], 32'h2);
    for (int i = 0; i < 6; i++) chk("mem_t4", 16+i, mem[16+i], 32'hA0 + 32'(i));
    for (int i = 0; i < 11; i++) chk("mem_t6", 32+i, mem[32+i], 32'hB00 + 32'(i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
